uart_stim_tx: RTL and testbench
===============================

UART_STIM_TX -- requirements
Module: uart_stim_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 434, giving clocks per UART bit (50 MHz / 115200); legal values are 2 or more.
REQ-002 The block SHALL have parameter FIFO_AW, default 4, giving a FIFO depth of 2^FIFO_AW bytes.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_i, input, 8 bits: byte offered for transmission.
REQ-006 The block SHALL have port valid_i, input, 1 bit: data_i is valid.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the FIFO can accept a byte.
REQ-008 The block SHALL have port tx_o, output, 1 bit: serial line driving the DUT uart0_srx_pad_i; idle level is high.
REQ-009 The block SHALL have port busy_o, output, 1 bit: a frame is being shifted out, or the FIFO is non-empty.
REQ-010 The block SHALL have port fifo_count_o, output, FIFO_AW+1 bits: current FIFO occupancy.

Function
REQ-011 A byte SHALL be written into the FIFO on every rising edge where valid_i and ready_o are both 1; ready_o SHALL equal NOT full and SHALL NOT depend on valid_i.
REQ-012 A write attempted while the FIFO is full SHALL be ignored: no overwrite, and the count is unchanged.
REQ-013 The FIFO SHALL use wrapping read and write pointers of FIFO_AW bits; fifo_count_o SHALL range from 0 to 2^FIFO_AW.
REQ-014 A simultaneous push and pop SHALL leave fifo_count_o unchanged and preserve byte order.
REQ-015 The FSM states SHALL be IDLE, START, DATA, STOP, plus PARITY when that feature is compiled in (see Configuration).
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte into the shift register, load the bit timer, and enter START on the same edge.
REQ-017 In START, tx_o SHALL be 0 for exactly BAUD_DIV clocks.
REQ-018 In DATA, the FSM SHALL send 8 bits LSB first, each for exactly BAUD_DIV clocks.
REQ-019 In STOP, tx_o SHALL be 1 for exactly BAUD_DIV clocks; the FSM then returns to IDLE.
REQ-020 The bit timer SHALL count from BAUD_DIV-1 down to 0; a state or bit advance SHALL occur only on the terminal count.
REQ-021 Latency: with the FSM in IDLE and the FIFO empty, tx_o SHALL fall one clock after the edge that accepts the byte.
REQ-022 Back-to-back frames: when the FIFO is non-empty at the end of STOP, the next START SHALL begin on the following clock, with no extra idle bit time.
REQ-023 tx_o SHALL be registered, with no combinational path from any input.
REQ-024 busy_o SHALL equal (state != IDLE) OR (fifo_count_o != 0).

Reset
REQ-025 While wb_rst_i is high, the block SHALL hold tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0, state=IDLE, with both FIFO pointers and the bit timer cleared.
REQ-026 Reset asserted mid-frame SHALL force tx_o high immediately (asynchronously), discard the partial frame and all FIFO contents, and restart no transmission until a new write.
REQ-027 Reset deassertion SHALL be synchronised internally; the first write SHALL be accepted no earlier than the second edge after release.

Configuration
REQ-028 With macro UART_STIM_PARITY_EN defined, the FSM SHALL insert a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for BAUD_DIV clocks; frames are 11 bits.
REQ-029 Without UART_STIM_PARITY_EN, no parity logic SHALL exist; frames are 10 bits (8N1).

Verification
REQ-030 Single byte: BAUD_DIV=4, write 0xA5 -> tx_o shows 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit, 40 clocks total; busy_o falls after STOP.
REQ-031 Fill to full: FIFO_AW=2, tx stalled mid-frame, write 5 bytes in consecutive cycles -> ready_o low after 4 accepted bytes, 5th dropped, fifo_count_o=4.
REQ-032 Back-to-back: write 0x00 then 0xFF -> the second start bit immediately follows the first stop bit; frames are contiguous, 80 clocks at BAUD_DIV=4.
REQ-033 Simultaneous push/pop: count=2, push on the pop edge -> count stays 2; the output byte order matches the write order.
REQ-034 Mid-frame reset: assert wb_rst_i during DATA bit 3 -> tx_o=1 within the same cycle, fifo_count_o=0, no frame after release until a new write.
REQ-035 Parity build: with UART_STIM_PARITY_EN, write 0x07 -> parity bit 1, 11-bit frame, 44 clocks at BAUD_DIV=4.

Source files
------------

// File: rtl/uart_stim_tx.sv
//------------------------------------------------------------------------------
// Module  : uart_stim_tx
// Brief   : FIFO-buffered 8N1 UART transmitter used to stimulate a UART receiver.
//           Optional even parity when UART_STIM_PARITY_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_stim_tx #(
   parameter int BAUD_DIV = 434,
   parameter int FIFO_AW  = 4
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [7:0]         data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               tx_o,
   output logic               busy_o,
   output logic [FIFO_AW:0]   fifo_count_o
);

   localparam int               TW         = $clog2(BAUD_DIV);
   localparam int               DEPTH      = 1 << FIFO_AW;
   localparam logic [TW-1:0]    TIMER_LOAD = TW'(BAUD_DIV - 1);
   localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_STIM_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   // Reset asserts immediately but releases only after two clean edges.
   logic [1:0] rst_pipe;
   logic       rst_int;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) rst_pipe <= 2'b11;
      else          rst_pipe <= {rst_pipe[0], 1'b0};
   end

   assign rst_int = rst_pipe[1];

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   logic [2:0]         state;
   logic [TW-1:0]      timer;
   logic               tick;
   logic [7:0]         shreg;
   logic [2:0]         bit_idx;
`ifdef UART_STIM_PARITY_EN
   logic               parity;
`endif

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign push    = valid_i & ~full & ~rst_int;
   // Low only during the post-release synchronisation window or when full.
   assign ready_o = ~full & ~(rst_int & ~wb_rst_i);
   assign tick    = (timer == '0);
   // A pop at the end of STOP chains the next frame with no idle gap.
   assign pop     = ~empty & ((state == S_IDLE) | ((state == S_STOP) & tick));

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge wb_clk_i or posedge rst_int) begin
      if (rst_int) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge rst_int) begin
      if (rst_int) begin
         state   <= S_IDLE;
         timer   <= '0;
         shreg   <= '0;
         bit_idx <= '0;
         tx_o    <= 1'b1;
`ifdef UART_STIM_PARITY_EN
         parity  <= 1'b0;
`endif
      end else if (pop) begin
         state   <= S_START;
         timer   <= TIMER_LOAD;
         shreg   <= mem[rd_ptr];
         bit_idx <= '0;
         tx_o    <= 1'b0;
`ifdef UART_STIM_PARITY_EN
         parity  <= ^mem[rd_ptr];
`endif
      end else if (state != S_IDLE) begin
         if (!tick) begin
            timer <= timer - 1'b1;
         end else begin
            timer <= TIMER_LOAD;
            case (state)
               S_START: begin
                  state <= S_DATA;
                  tx_o  <= shreg[0];
               end
               S_DATA: begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_STIM_PARITY_EN
                     state <= S_PARITY;
                     tx_o  <= parity;
`else
                     state <= S_STOP;
                     tx_o  <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx_o    <= shreg[1];
                  end
               end
`ifdef UART_STIM_PARITY_EN
               S_PARITY: begin
                  state <= S_STOP;
                  tx_o  <= 1'b1;
               end
`endif
               S_STOP: begin
                  state <= S_IDLE;
                  tx_o  <= 1'b1;
               end
               default: begin
                  state <= S_IDLE;
                  tx_o  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign busy_o       = (state != S_IDLE) | ~empty;
   assign fifo_count_o = count;

endmodule

`default_nettype wire

// File: tb/tb_uart_stim_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_stim_tx
// Brief   : Scoreboard bench for uart_stim_tx with a serial-line frame monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_stim_tx;

   localparam int BAUD = 4;
   localparam int AW   = 2;
`ifdef UART_STIM_PARITY_EN
   localparam int FB   = 11;
`else
   localparam int FB   = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data = 8'h00;
   logic        valid = 1'b0;
   logic        ready_o;
   logic        tx_o;
   logic        busy_o;
   logic [AW:0] fifo_count_o;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          mon_busy = 1'b0;
   logic [7:0]  expq[$];
   int          starts[$];

   uart_stim_tx #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .data_i       (data),
      .valid_i      (valid),
      .ready_o      (ready_o),
      .tx_o         (tx_o),
      .busy_o       (busy_o),
      .fifo_count_o (fifo_count_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference frame: start, data LSB first, optional even parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_STIM_PARITY_EN
      f[9] = ^b;
`endif
      return f;
   endfunction

   // Line monitor: decodes every frame cycle-exactly against the scoreboard.
   initial begin
      logic [10:0] fr;
      logic [7:0]  b;
      int          errs;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (!rst && tx_o === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            if (expq.size() == 0) begin
               check_eq("unexpected_frame", 1, 0);
               repeat (FB * BAUD - 1) @(negedge clk);
            end else begin
               b = expq.pop_front();
               fr = frame_of(b);
               errs = 0;
               aborted = 1'b0;
               for (int i = 0; i < FB * BAUD; i++) begin
                  if (i > 0) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx_o !== fr[i / BAUD]) errs++;
               end
               if (!aborted) check_eq($sformatf("frame_0x%02h_bad_cycles", b), errs, 0);
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic drive(input logic [7:0] b);
      @(negedge clk);
      data  = b;
      valid = 1'b1;
   endtask

   task automatic idle_cyc();
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic send_hs(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      while (!ready_o && t < 1000) begin
         valid = 1'b0;
         @(negedge clk);
         t++;
      end
      if (t >= 1000) check_eq("ready_timeout", t, 0);
      data  = b;
      valid = 1'b1;
      expq.push_back(b);
   endtask

   task automatic drain(input int max);
      int t = 0;
      idle_cyc();
      while ((busy_o || mon_busy || expq.size() != 0) && t < max) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain_in_time", int'(t < max), 1);
   endtask

   initial begin
      int n;
      int mc;
      logic [7:0] b;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_tx", tx_o, 1);
      check_eq("rst_ready", ready_o, 1);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_count", fifo_count_o, 0);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single byte: latency, frame, busy release
      drive(8'hA5);
      expq.push_back(8'hA5);
      idle_cyc();
      check_eq("lat_tx_still_high", tx_o, 1);
      check_eq("lat_busy", busy_o, 1);
      idle_cyc();
      check_eq("lat_tx_low", tx_o, 0);
      repeat (FB * BAUD - 1) idle_cyc();
      check_eq("stop_busy_high", busy_o, 1);
      check_eq("stop_tx_high", tx_o, 1);
      idle_cyc();
      check_eq("busy_after_stop", busy_o, 0);
      drain(200);

      // Fill to full while the first frame is stalling the FIFO
      drive(8'h3C);
      expq.push_back(8'h3C);
      idle_cyc();
      mc = 0;
      for (int k = 0; k < 5; k++) begin
         b = 8'h10 + 8'(k);
         @(negedge clk);
         check_eq($sformatf("fill_ready_%0d", k), ready_o, int'(mc < 4));
         data  = b;
         valid = 1'b1;
         if (mc < 4) begin
            expq.push_back(b);
            mc++;
         end
      end
      idle_cyc();
      check_eq("full_count", fifo_count_o, 4);
      check_eq("full_ready", ready_o, 0);
      drain(400);

      // Back-to-back frames
      n = starts.size();
      drive(8'h00);
      expq.push_back(8'h00);
      drive(8'hFF);
      expq.push_back(8'hFF);
      drain(300);
      check_eq("b2b_frames", starts.size() - n, 2);
      if (starts.size() - n == 2)
         check_eq("b2b_spacing", starts[n+1] - starts[n], FB * BAUD);

      // Push on the pop edge keeps occupancy and order
      drive(8'h81);
      expq.push_back(8'h81);
      drive(8'h42);
      expq.push_back(8'h42);
      drive(8'hC3);
      expq.push_back(8'hC3);
      repeat (FB * BAUD - 2) idle_cyc();
      check_eq("pp_count_before", fifo_count_o, 2);
      drive(8'h5A);
      expq.push_back(8'h5A);
      idle_cyc();
      check_eq("pp_count_after", fifo_count_o, 2);
      check_eq("pp_next_start", tx_o, 0);
      drain(600);

      // Randomised traffic with handshake
      for (int k = 0; k < 24; k++) begin
         send_hs(8'($urandom));
         repeat ($urandom_range(0, 3)) idle_cyc();
         if ($urandom_range(0, 7) == 0) repeat (60) idle_cyc();
      end
      drain(3000);

      // Mid-frame reset during data bit 3
      drive(8'h37);
      expq.push_back(8'h37);
      drive(8'hAA);
      expq.push_back(8'hAA);
      drive(8'h55);
      expq.push_back(8'h55);
      repeat (17) idle_cyc();
      check_eq("pre_reset_tx_bit3", tx_o, 0);
      #2 rst = 1'b1;
      expq.delete();
      #1;
      check_eq("mid_rst_tx", tx_o, 1);
      check_eq("mid_rst_count", fifo_count_o, 0);
      check_eq("mid_rst_busy", busy_o, 0);
      check_eq("mid_rst_ready", ready_o, 1);
      repeat (3) @(negedge clk);
      n = starts.size();
      #2 rst = 1'b0;
      data  = 8'h99;
      valid = 1'b1;
      idle_cyc();
      check_eq("first_edge_write_ignored", fifo_count_o, 0);
      repeat (100) idle_cyc();
      check_eq("no_frame_after_rst", starts.size() - n, 0);
      check_eq("post_rst_tx", tx_o, 1);
      check_eq("post_rst_busy", busy_o, 0);

      // Transmission resumes on a new write
      drive(8'h07);
      expq.push_back(8'h07);
      drain(200);
      check_eq("resume_frame", starts.size() - n, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
